// File: rtl/spi_frame_latch.sv
// spi_frame_latch
//   Holds the GPIO/routing outputs steady while the SPI shift register is
//   shifting. The shift register's parallel contents are committed only after
//   a frame of exactly WIDTH spi_clk rising edges has been framed by spi_ss.
//   Frames that are short, long, empty or followed too early by a new frame
//   are rejected and flagged.
//
// Ports
//   clk          main clock (same clock as the shift register)
//   nreset       asynchronous active-low reset
//   spi_clk      raw SPI clock pin, mode 0 (idle low)
//   spi_ss       raw SPI slave select pin, active low
//   shift_data   parallel output of the shift register
//   latch_out    committed value driving the GPIO outputs
//   latch_strobe one-cycle pulse in the cycle latch_out takes a new value
//   frame_err    sticky: the last completed frame was rejected
module spi_frame_latch #(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             spi_clk,
   input  logic             spi_ss,
   input  logic [WIDTH-1:0] shift_data,
   output logic [WIDTH-1:0] latch_out,
   output logic             latch_strobe,
   output logic             frame_err
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 2);
   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      SETTLE,
      COMMIT
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic                   sck_prev;
   logic                   ss_s;
   logic                   sck_s;
   logic                   sck_rise;

   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [SET_W-1:0] settle_cnt, settle_cnt_n;
   logic [WIDTH-1:0] latch_n;
   logic             strobe_n;
   logic             err_n;

   // Synchronisers: slave select idles deasserted (high), SPI clock idles low,
   // so reset values match the bus idle state and produce no false edges.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ss_sync  <= '1;
         sck_sync <= '0;
         sck_prev <= 1'b0;
      end else begin
         ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         sck_prev <= sck_s;
      end
   end

   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         settle_cnt   <= '0;
         latch_out    <= '0;
         latch_strobe <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state        <= state_n;
         bit_cnt      <= bit_cnt_n;
         settle_cnt   <= settle_cnt_n;
         latch_out    <= latch_n;
         latch_strobe <= strobe_n;
         frame_err    <= err_n;
      end
   end

   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      settle_cnt_n = settle_cnt;
      latch_n      = latch_out;
      strobe_n     = 1'b0;
      err_n        = frame_err;

      case (state)
         IDLE: begin
            if (!ss_s) begin
               state_n   = ACTIVE;
               bit_cnt_n = '0;
            end
         end

         ACTIVE: begin
            // Counting is independent of ss_s so an edge arriving together
            // with the deselect still belongs to this frame. The count
            // saturates one above WIDTH so any over-length frame stays long.
            if (sck_rise && (bit_cnt != CNT_MAX)) begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
            if (ss_s) begin
               state_n      = SETTLE;
               settle_cnt_n = SET_LOAD;
            end
         end

         SETTLE: begin
            if (!ss_s) begin
               // Reselected before the shift register was sampled: the new
               // frame is tracked from scratch and the old one is dropped.
               err_n     = 1'b1;
               state_n   = ACTIVE;
               bit_cnt_n = '0;
            end else if (settle_cnt == '0) begin
               state_n = COMMIT;
            end else begin
               settle_cnt_n = settle_cnt - 1'b1;
            end
         end

         COMMIT: begin
            state_n = IDLE;
            if (bit_cnt == CNT_FULL) begin
               latch_n  = shift_data;
               strobe_n = 1'b1;
               err_n    = 1'b0;
            end else begin
               err_n = 1'b1;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_frame_latch.sv
// Testbench for spi_frame_latch: directed SPI frames, a frame-level
// reference model compared every cycle, and literal spot checks.
module tb_spi_frame_latch;

   localparam int WIDTH  = 16;
   localparam int SYNC   = 2;
   localparam int SETTLE = 2;

   logic             clk = 1'b0;
   logic             nreset;
   logic             spi_clk;
   logic             spi_ss;
   logic             mosi;
   logic [WIDTH-1:0] shift_data = '0;
   logic [WIDTH-1:0] latch_out;
   logic             latch_strobe;
   logic             frame_err;

   int n_checks  = 0;
   int n_fail    = 0;
   int n_strobes = 0;

   // reference model state
   logic [WIDTH-1:0] exp_latch;
   logic             exp_strobe;
   logic             exp_err;
   int               cyc, bits, end_at, commit_at, abort_at;
   bit               commit_pend, abort_pend, commit_ok, in_frame;
   bit               prev_ss, prev_sck;

   always #5 clk = ~clk;

   // external shift register feeding the DUT (MSB first, mode 0)
   always @(posedge spi_clk) shift_data <= {shift_data[WIDTH-2:0], mosi};

   spi_frame_latch #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk),
      .nreset(nreset),
      .spi_clk(spi_clk),
      .spi_ss(spi_ss),
      .shift_data(shift_data),
      .latch_out(latch_out),
      .latch_strobe(latch_strobe),
      .frame_err(frame_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Frame-level model. Pin events are indexed by the first clk edge that
   // sees them. A frame owns the spi_clk rises after its select edge up to
   // and including its deselect edge; the outcome lands SYNC+SETTLE+1 edges
   // after the deselect edge. A reselect seen within SETTLE edges of the
   // deselect cancels the commit and raises the error SYNC edges later.
   task automatic model_step();
      bit fall, rise;
      if (!nreset) begin
         exp_latch = '0; exp_strobe = 1'b0; exp_err = 1'b0;
         cyc = 0; bits = 0; commit_pend = 0; abort_pend = 0; in_frame = 0;
         prev_ss = 1'b1; prev_sck = 1'b0;
         return;
      end
      cyc++;
      exp_strobe = 1'b0;
      if (commit_pend && cyc == commit_at) begin
         commit_pend = 0;
         if (commit_ok) begin
            exp_latch  = shift_data;
            exp_strobe = 1'b1;
            exp_err    = 1'b0;
         end else begin
            exp_err = 1'b1;
         end
      end
      if (abort_pend && cyc == abort_at) begin
         abort_pend = 0;
         exp_err    = 1'b1;
      end
      fall = (spi_ss == 1'b0) && prev_ss;
      rise = (spi_ss == 1'b1) && !prev_ss;
      if (fall) begin
         if (commit_pend && cyc <= end_at + SETTLE) begin
            commit_pend = 0;
            abort_pend  = 1;
            abort_at    = cyc + SYNC;
         end
         in_frame = 1;
         bits     = 0;
      end else if (spi_clk && !prev_sck && in_frame) begin
         bits++;
      end
      if (rise && in_frame) begin
         in_frame    = 0;
         commit_pend = 1;
         commit_ok   = (bits == WIDTH);
         end_at      = cyc;
         commit_at   = cyc + SYNC + SETTLE + 1;
      end
      prev_ss  = spi_ss;
      prev_sck = spi_clk;
   endtask

   task automatic compare();
      check("latch_out", 32'(latch_out), 32'(exp_latch));
      check("latch_strobe", 32'(latch_strobe), 32'(exp_strobe));
      check("frame_err", 32'(frame_err), 32'(exp_err));
   endtask

   // advance n clk cycles, sampling 1 time unit after each rising edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         model_step();
         compare();
         if (latch_strobe) n_strobes++;
      end
   endtask

   // n spi_clk pulses, MSB of the n-bit pattern first, clk/6 SPI clock;
   // coinc puts the final rise on the same clk cycle as the deselect
   task automatic shift_bits(input logic [31:0] data, input int n, input bit coinc);
      for (int i = 0; i < n; i++) begin
         int idx = n - 1 - i;
         mosi = data[idx];
         tick(3);
         spi_clk = 1'b1;
         if (coinc && i == n - 1) spi_ss = 1'b1;
         tick(3);
         spi_clk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] data, input int n);
      spi_ss = 1'b0;
      tick(4);
      shift_bits(data, n, 1'b0);
      tick(3);
      spi_ss = 1'b1;
      tick(12);
   endtask

   initial begin
      int s0;
      nreset  = 1'b0;
      spi_clk = 1'b0;
      spi_ss  = 1'b1;
      mosi    = 1'b0;
      tick(3);
      check("reset_latch", 32'(latch_out), 32'h0);
      check("reset_strobe", 32'(latch_strobe), 32'h0);
      check("reset_err", 32'(frame_err), 32'h0);
      nreset = 1'b1;
      tick(4);

      // good frame with exact latency from the deselect
      spi_ss = 1'b0;
      tick(4);
      shift_bits(32'hA5C3, 16, 1'b0);
      tick(3);
      spi_ss = 1'b1;
      tick(5);
      check("good_before_commit", 32'(latch_out), 32'h0);
      tick(1);
      check("good_latch", 32'(latch_out), 32'hA5C3);
      check("good_strobe_on", 32'(latch_strobe), 32'h1);
      tick(1);
      check("good_strobe_off", 32'(latch_strobe), 32'h0);
      tick(10);
      check("good_err", 32'(frame_err), 32'h0);

      // short frame
      s0 = n_strobes;
      frame(32'h7E81, 15);
      check("short_latch", 32'(latch_out), 32'hA5C3);
      check("short_err", 32'(frame_err), 32'h1);
      check("short_strobes", 32'(n_strobes - s0), 32'h0);

      // long frames, then a good one
      frame(32'h0001_2345, 17);
      check("long17_latch", 32'(latch_out), 32'hA5C3);
      check("long17_err", 32'(frame_err), 32'h1);
      frame(32'h2AAA_AAAA, 30);
      check("long30_latch", 32'(latch_out), 32'hA5C3);
      check("long30_err", 32'(frame_err), 32'h1);
      frame(32'h0F0F, 16);
      check("good2_latch", 32'(latch_out), 32'h0F0F);
      check("good2_err", 32'(frame_err), 32'h0);

      // early reselect inside the settle window
      s0 = n_strobes;
      spi_ss = 1'b0;
      tick(4);
      shift_bits(32'hDEAD, 16, 1'b0);
      tick(3);
      spi_ss = 1'b1;
      tick(2);
      spi_ss = 1'b0;
      tick(8);
      check("reselect_err", 32'(frame_err), 32'h1);
      check("reselect_strobes", 32'(n_strobes - s0), 32'h0);
      check("reselect_latch", 32'(latch_out), 32'h0F0F);
      shift_bits(32'h1234, 16, 1'b0);
      tick(3);
      spi_ss = 1'b1;
      tick(12);
      check("after_reselect_latch", 32'(latch_out), 32'h1234);
      check("after_reselect_err", 32'(frame_err), 32'h0);

      // last spi_clk rise coincident with the deselect
      s0 = n_strobes;
      spi_ss = 1'b0;
      tick(4);
      shift_bits(32'h5AA5, 16, 1'b1);
      tick(12);
      check("coinc_latch", 32'(latch_out), 32'h5AA5);
      check("coinc_err", 32'(frame_err), 32'h0);
      check("coinc_strobes", 32'(n_strobes - s0), 32'h1);

      // zero-length frame
      spi_ss = 1'b0;
      tick(6);
      spi_ss = 1'b1;
      tick(12);
      check("zero_err", 32'(frame_err), 32'h1);
      check("zero_latch", 32'(latch_out), 32'h5AA5);

      // asynchronous reset in the middle of a frame
      spi_ss = 1'b0;
      tick(4);
      shift_bits(32'hBE, 8, 1'b0);
      spi_clk = 1'b1;
      #2;
      nreset = 1'b0;
      #1;
      check("async_reset_latch", 32'(latch_out), 32'h0);
      check("async_reset_strobe", 32'(latch_strobe), 32'h0);
      check("async_reset_err", 32'(frame_err), 32'h0);
      tick(3);
      spi_clk = 1'b0;
      shift_bits(32'h5, 4, 1'b0);
      s0 = n_strobes;
      nreset = 1'b1;
      shift_bits(32'hA, 4, 1'b0);
      tick(3);
      spi_ss = 1'b1;
      tick(12);
      check("post_reset_partial_strobes", 32'(n_strobes - s0), 32'h0);
      check("post_reset_partial_latch", 32'(latch_out), 32'h0);
      check("post_reset_partial_err", 32'(frame_err), 32'h1);
      frame(32'hBEEF, 16);
      check("post_reset_good_latch", 32'(latch_out), 32'hBEEF);
      check("post_reset_good_err", 32'(frame_err), 32'h0);
      check("post_reset_good_strobes", 32'(n_strobes - s0), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
